// File: rtl/cdc_pulse_arbiter.sv
// Round-robin scheduler sharing one four-phase req/ack crossing among N pulse requesters; grant 1 edge after pend, retire after ack-low.
// Backpressure: events stay latched in pend until served; repeats merge (drop pulse). CDC_ARB_TIMEOUT_EN adds a REQ timeout abort.
module cdc_pulse_arbiter #(
    parameter int N       = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    pulse_in_i,
    input  logic            ack_sync_i,
    output logic            chan_req_o,
    output logic [ID_W-1:0] chan_id_o,
    output logic [N-1:0]    pend_o,
    output logic [N-1:0]    done_o,
    output logic [N-1:0]    drop_o,
    output logic            busy_o,
    output logic            timeout_err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    if (N < 2 || N > 16 || (1 << ID_W) < N || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_params
        $error("cdc_pulse_arbiter: illegal parameter combination");
    end

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] chan_id_q, chan_id_d;
    logic            chan_req_q, chan_req_d;
    logic [N-1:0]    pend_q, pend_d;
    logic [N-1:0]    done_q, done_d;
    logic [N-1:0]    drop_q, drop_d;
    logic [N-1:0]    grant_clr;
    logic            grant;

    logic            hi_vld, lo_vld, win_vld;
    logic [ID_W-1:0] hi_id, lo_id, win_id;

`ifdef CDC_ARB_TIMEOUT_EN
    logic [15:0]     cnt_q, cnt_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    // Lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        hi_vld = 1'b0;
        hi_id  = '0;
        lo_vld = 1'b0;
        lo_id  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                lo_vld = 1'b1;
                lo_id  = ID_W'(i);
            end
            if (pend_q[i] && (i >= int'(ptr_q))) begin
                hi_vld = 1'b1;
                hi_id  = ID_W'(i);
            end
        end
        win_vld = lo_vld;
        win_id  = hi_vld ? hi_id : lo_id;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        chan_id_d  = chan_id_q;
        chan_req_d = chan_req_q;
        done_d     = '0;
        grant      = 1'b0;
`ifdef CDC_ARB_TIMEOUT_EN
        cnt_d         = '0;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A lingering ack from an aborted or reset handshake blocks new grants.
                if (win_vld && !ack_sync_i) begin
                    grant      = 1'b1;
                    chan_id_d  = win_id;
                    chan_req_d = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (ack_sync_i) begin
                    chan_req_d = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        done_d[i] = (chan_id_q == ID_W'(i));
                    end
                    state_d = WAIT_LOW;
                end
`ifdef CDC_ARB_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    chan_req_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = WAIT_LOW;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            WAIT_LOW: begin
                if (!ack_sync_i) begin
                    ptr_d   = (chan_id_q == ID_W'(N - 1)) ? '0 : chan_id_q + ID_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A new pulse on the grant edge re-arms the flag, so the event is served again later.
    always_comb begin
        grant_clr = '0;
        for (int i = 0; i < N; i++) begin
            grant_clr[i] = grant && (win_id == ID_W'(i));
        end
        pend_d = pulse_in_i | (pend_q & ~grant_clr);
        drop_d = pulse_in_i & pend_q & ~grant_clr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            chan_id_q  <= '0;
            chan_req_q <= 1'b0;
            pend_q     <= '0;
            done_q     <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            chan_id_q  <= chan_id_d;
            chan_req_q <= chan_req_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

`ifdef CDC_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign chan_req_o = chan_req_q;
    assign chan_id_o  = chan_id_q;
    assign pend_o     = pend_q;
    assign done_o     = done_q;
    assign drop_o     = drop_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_pulse_arbiter.sv
// Scoreboard bench for cdc_pulse_arbiter: expected grants/dones/drops queued at stimulus time, popped by a monitor.
module tb_cdc_pulse_arbiter;
    localparam int N    = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    pulse_in;
    logic            ack_sync;
    logic            chan_req_o;
    logic [ID_W-1:0] chan_id_o;
    logic [N-1:0]    pend_o, done_o, drop_o;
    logic            busy_o, timeout_err_o;

    int           checks = 0;
    int           errors = 0;
    int           exp_grant[$];
    logic [N-1:0] exp_done[$];
    logic [N-1:0] exp_drop[$];
    int           to_expect = 0;
    int           m_ptr = 0;
    logic         hold = 1'b0;
    logic         man_en = 1'b0;
    logic         man_ack = 1'b0;

    always #5 clk = ~clk;

    cdc_pulse_arbiter #(.N(N), .ID_W(ID_W), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst), .pulse_in_i(pulse_in), .ack_sync_i(ack_sync),
        .chan_req_o(chan_req_o), .chan_id_o(chan_id_o), .pend_o(pend_o),
        .done_o(done_o), .drop_o(drop_o), .busy_o(busy_o), .timeout_err_o(timeout_err_o)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    function automatic void expect_id(input int id);
        exp_grant.push_back(id);
        exp_done.push_back(onehot(id));
        m_ptr = (id + 1) % N;
    endfunction

    // Slow-side responder: ack follows req after a random delay, unless held or manually driven.
    initial begin
        int dly;
        dly = 0;
        ack_sync = 1'b0;
        forever begin
            @(negedge clk);
            if (man_en) ack_sync = man_ack;
            else if (!hold && ack_sync != chan_req_o) begin
                if (dly == 0) begin
                    ack_sync = chan_req_o;
                    dly = $urandom_range(0, 3);
                end else dly--;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant, done, drop or abort.
    initial begin
        logic            prev_req;
        logic [ID_W-1:0] prev_id;
        int              e;
        prev_req = 1'b0;
        prev_id  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) prev_req = 1'b0;
            else begin
                if (chan_req_o && !prev_req) begin
                    if (exp_grant.size() == 0) bound_fail("grant_unexpected");
                    else begin
                        e = exp_grant.pop_front();
                        check("grant_id", int'(chan_id_o), e);
                    end
                end else if (chan_req_o) check("id_stable", int'(chan_id_o), int'(prev_id));
                if (done_o != '0) begin
                    if (exp_done.size() == 0) bound_fail("done_unexpected");
                    else check("done", int'(done_o), int'(exp_done.pop_front()));
                end
                if (drop_o != '0) begin
                    if (exp_drop.size() == 0) bound_fail("drop_unexpected");
                    else check("drop", int'(drop_o), int'(exp_drop.pop_front()));
                end
                if (timeout_err_o) begin
                    if (to_expect == 0) bound_fail("timeout_err_unexpected");
                    else begin
                        to_expect--;
                        checks++;
                    end
                end
                prev_req = chan_req_o;
                prev_id  = chan_id_o;
            end
        end
    end

    task automatic drive_pulse(input logic [N-1:0] m, input int cycles);
        @(negedge clk);
        pulse_in = m;
        repeat (cycles) @(negedge clk);
        pulse_in = '0;
    endtask

    task automatic wait_req();
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            if (chan_req_o) return;
        end
        bound_fail("req_wait");
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            if (!busy_o && !ack_sync && exp_grant.size() == 0 && exp_done.size() == 0) begin
                check("drain_pend", int'(pend_o), 0);
                check("drain_drops_left", exp_drop.size(), 0);
                return;
            end
        end
        bound_fail("drain_wait");
        exp_grant.delete();
        exp_done.delete();
        exp_drop.delete();
    endtask

    // Idle batch: served once each, in round-robin order from the model pointer.
    task automatic batch(input logic [N-1:0] m, output int first);
        int start;
        int id;
        start = m_ptr;
        first = -1;
        for (int k = 0; k < N; k++) begin
            id = (start + k) % N;
            if (m[id]) begin
                if (first < 0) first = id;
                expect_id(id);
            end
        end
        drive_pulse(m, 1);
    endtask

    // Pulse while `cur` is stalled in REQ: pending set is whatever is still queued for grant.
    task automatic stall_pulse(input logic [N-1:0] m, input int cur);
        logic [N-1:0] pn;
        int id;
        @(negedge clk);
        pn = '0;
        foreach (exp_grant[j]) pn[exp_grant[j]] = 1'b1;
        if ((m & pn) != '0) exp_drop.push_back(m & pn);
        pn = pn | m;
        exp_grant.delete();
        exp_done.delete();
        exp_done.push_back(onehot(cur));
        for (int k = 1; k <= N; k++) begin
            id = (cur + k) % N;
            if (pn[id]) expect_id(id);
        end
        pulse_in = m;
        @(negedge clk);
        pulse_in = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_grant.delete();
        exp_done.delete();
        exp_drop.delete();
        m_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int first;
        int ns;
        rst = 1'b1;
        pulse_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_chan_req", int'(chan_req_o), 0);
        check("rst_chan_id", int'(chan_id_o), 0);
        check("rst_pend", int'(pend_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_drop", int'(drop_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_timeout_err", int'(timeout_err_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single event with a manually driven 4-cycle ack.
        man_en = 1'b1;
        man_ack = 1'b0;
        expect_id(0);
        @(negedge clk);
        pulse_in = 4'b0001;
        @(posedge clk); #1;
        check("t1_pend_set", int'(pend_o), 1);
        check("t1_req_not_yet", int'(chan_req_o), 0);
        @(negedge clk);
        pulse_in = '0;
        @(posedge clk); #1;
        check("t1_req_rise", int'(chan_req_o), 1);
        check("t1_chan_id", int'(chan_id_o), 0);
        check("t1_busy", int'(busy_o), 1);
        repeat (3) @(posedge clk);
        #1;
        man_ack = 1'b1;
        @(posedge clk); #1;
        check("t1_req_fall", int'(chan_req_o), 0);
        check("t1_done", int'(done_o), 1);
        @(posedge clk); #1;
        check("t1_done_once", int'(done_o), 0);
        check("t1_busy_wait_low", int'(busy_o), 1);
        @(posedge clk); #1;
        man_ack = 1'b0;
        @(posedge clk); #1;
        check("t1_busy_fall", int'(busy_o), 0);
        man_en = 1'b0;
        wait_idle();

        // All four at once from ptr 0.
        do_reset();
        expect_id(0); expect_id(1); expect_id(2); expect_id(3);
        drive_pulse(4'b1111, 1);
        wait_idle();

        // Wrap: ptr is 0 after serving ID 3, so 1 precedes 3.
        expect_id(1); expect_id(3);
        drive_pulse(4'b1010, 1);
        wait_idle();

        // Merge: ID 2 pulsed twice while ID 0 is stalled in REQ.
        hold = 1'b1;
        expect_id(0);
        drive_pulse(4'b0001, 1);
        wait_req();
        stall_pulse(4'b0100, 0);
        stall_pulse(4'b0100, 0);
        repeat (2) @(negedge clk);
        hold = 1'b0;
        wait_idle();

        // Pulse on the grant edge re-arms: ID 2 served twice, no drop.
        expect_id(2); expect_id(2);
        drive_pulse(4'b0100, 2);
        wait_idle();

        // Reset mid-REQ with ptr at 3 and pend 1010.
        hold = 1'b1;
        expect_id(0);
        drive_pulse(4'b0001, 1);
        wait_req();
        stall_pulse(4'b1010, 0);
        check("rq_pend_before_rst", int'(pend_o), 4'b1010);
        rst = 1'b1;
        exp_grant.delete();
        exp_done.delete();
        exp_drop.delete();
        @(posedge clk); #1;
        check("rq_chan_req", int'(chan_req_o), 0);
        check("rq_pend", int'(pend_o), 0);
        check("rq_busy", int'(busy_o), 0);
        @(negedge clk);
        rst = 1'b0;
        hold = 1'b0;
        m_ptr = 0;
        expect_id(0); expect_id(3);
        drive_pulse(4'b1001, 1);
        wait_idle();

        // REQ stall with no ack: aborts after 8 cycles when the timeout is built in.
        hold = 1'b1;
        exp_grant.push_back(0);
        exp_grant.push_back(1);
`ifdef CDC_ARB_TIMEOUT_EN
        exp_done.push_back(4'b0010);
        to_expect = 1;
`else
        exp_done.push_back(4'b0001);
        exp_done.push_back(4'b0010);
`endif
        m_ptr = 2;
        drive_pulse(4'b0011, 1);
        wait_req();
`ifdef CDC_ARB_TIMEOUT_EN
        repeat (7) @(posedge clk);
        #1;
        check("to_not_early", int'(timeout_err_o), 0);
        @(posedge clk); #1;
        check("to_pulse", int'(timeout_err_o), 1);
        check("to_req_drop", int'(chan_req_o), 0);
`else
        repeat (20) @(posedge clk);
        #1;
        check("no_to_req_held", int'(chan_req_o), 1);
`endif
        hold = 1'b0;
        wait_idle();

        // Randomised batches, some with merges injected during a stalled handshake.
        for (int it = 0; it < 40; it++) begin
            logic stall;
            stall = ($urandom_range(0, 1) == 1);
            hold = stall;
            batch(4'($urandom_range(1, 15)), first);
            if (stall) begin
                wait_req();
                ns = $urandom_range(1, 3);
                for (int s = 0; s < ns; s++) stall_pulse(4'($urandom_range(1, 15)), first);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                hold = 1'b0;
            end
            wait_idle();
        end

        check("to_expect_left", to_expect, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
